// File: rtl/toggle_stim_gen.sv
// Single-bit stimulus source with random/toggle/hold burst modes.
// Each issued bit is flagged when it differs from the previous one, and the changes are counted per burst.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet, a holds
// RUN   | issuing rem more bits; rem==0 means the last bit is already out
// DONE  | one-cycle done pulse, busy still high
module toggle_stim_gen #(
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED   = 16'hACE1,
  parameter int                CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] len,
  output logic             a,
  output logic             a_vld,
  output logic             changed,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] chg_count
);

  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? LFSR_W'(1) : SEED;
  localparam logic [LFSR_W-1:0] TAPS     = LFSR_W'(16'hB400);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] rem;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] lfsr_nxt;
  logic             bit_nxt;

  assign lfsr_nxt = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);

  always_comb begin
    bit_nxt = lfsr[0];
    case (mode_q)
      2'b01:   bit_nxt = ~a;
      2'b10:   bit_nxt = a;
      default: bit_nxt = lfsr[0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode_q    <= 2'b00;
      rem       <= '0;
      lfsr      <= SEED_EFF;
      a         <= 1'b0;
      a_vld     <= 1'b0;
      changed   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      chg_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          a_vld   <= 1'b0;
          changed <= 1'b0;
          done    <= 1'b0;
          busy    <= 1'b0;
          // len==0 passes through RUN with nothing to issue, giving the same done timing
          if (start) begin
            mode_q    <= mode;
            rem       <= len;
            chg_count <= '0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (rem == '0) begin
            a_vld   <= 1'b0;
            changed <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            a       <= bit_nxt;
            a_vld   <= 1'b1;
            changed <= (bit_nxt != a);
            rem     <= rem - CNT_W'(1);
            if ((bit_nxt != a) && (chg_count != '1))
              chg_count <= chg_count + CNT_W'(1);
            if (mode_q != 2'b01 && mode_q != 2'b10)
              lfsr <= lfsr_nxt;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
